// File: rtl/branch_predictor_table.sv
// rtl/branch_predictor_table.sv - per-PC saturating-counter branch history table with optional gshare
module branch_predictor_table #(
    parameter int PC_W    = 32,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 0,
    parameter int MISS_W  = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [PC_W-1:0]                     i_pred_pc,
    output logic                                o_pred_taken,
    output logic [CNT_W-1:0]                    o_pred_cnt,
    output logic [INDEX_W-1:0]                  o_pred_idx,
    input  logic                                i_upd_valid,
    input  logic [INDEX_W-1:0]                  i_upd_idx,
    input  logic                                i_upd_taken,
    input  logic                                i_upd_pred,
    output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] o_ghr,
    output logic [MISS_W-1:0]                   o_miss_cnt
);

    localparam int GHR_OW = (GHR_W > 0) ? GHR_W : 1;
    localparam int DEPTH  = 2 ** INDEX_W;
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (CNT_W < 2 || CNT_W > 4) begin : g_bad_cnt_w
        $error("branch_predictor_table: CNT_W must be in 2..4");
    end
    if (GHR_W < 0 || GHR_W > INDEX_W) begin : g_bad_ghr_w
        $error("branch_predictor_table: GHR_W must be in 0..INDEX_W");
    end
    if (PC_W <= INDEX_W + 2) begin : g_bad_pc_w
        $error("branch_predictor_table: PC_W too small for INDEX_W");
    end

    logic [CNT_W-1:0]   bht_q [DEPTH];
    logic [GHR_OW-1:0]  ghr_q;
    logic [GHR_OW-1:0]  ghr_d;
    logic [MISS_W-1:0]  miss_q;
    logic [INDEX_W-1:0] pred_idx;

    // History is zero-extended into the low index bits; in bimodal mode ghr_q is held at 0.
    assign pred_idx     = i_pred_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
    assign o_pred_idx   = pred_idx;
    assign o_pred_cnt   = bht_q[pred_idx];
    assign o_pred_taken = bht_q[pred_idx][CNT_W-1];
    assign o_ghr        = ghr_q;
    assign o_miss_cnt   = miss_q;

    logic unused_pc;
    assign unused_pc = ^{i_pred_pc[PC_W-1:INDEX_W+2], i_pred_pc[1:0]};

    if (GHR_W > 1) begin : g_ghr_shift
        assign ghr_d = {ghr_q[GHR_OW-2:0], i_upd_taken};
    end else if (GHR_W == 1) begin : g_ghr_one
        assign ghr_d = i_upd_taken;
    end else begin : g_ghr_none
        assign ghr_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= WEAK_NT;
            end
        end else if (i_upd_valid) begin
            if (i_upd_taken) begin
                if (bht_q[i_upd_idx] != CNT_MAX) begin
                    bht_q[i_upd_idx] <= bht_q[i_upd_idx] + CNT_W'(1);
                end
            end else if (bht_q[i_upd_idx] != '0) begin
                bht_q[i_upd_idx] <= bht_q[i_upd_idx] - CNT_W'(1);
            end
        end
    end

    // Non-speculative history: shifted only when a branch resolves.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ghr_q <= '0;
        end else if (i_upd_valid) begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            miss_q <= '0;
        end else if (i_upd_valid && (i_upd_pred != i_upd_taken) && (miss_q != '1)) begin
            miss_q <= miss_q + MISS_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_table.sv
// tb/tb_branch_predictor_table.sv - bench for bimodal and gshare builds of branch_predictor_table
module tb_branch_predictor_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, rst_g;
    logic [31:0] b_pc, g_pc;
    logic        b_uv, g_uv, b_ut, g_ut, b_up, g_up;
    logic [5:0]  b_uidx, g_uidx;
    logic        b_taken, g_taken;
    logic [1:0]  b_cnt, g_cnt;
    logic [5:0]  b_idx, g_idx;
    logic [0:0]  b_ghr;
    logic [3:0]  g_ghr;
    logic [15:0] b_miss, g_miss;

    int total  = 0;
    int passed = 0;

    int mc [2][64];
    int mghr [2];
    int mmiss [2];
    int glen [2] = '{0, 4};

    branch_predictor_table dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_pred_pc(b_pc),
        .o_pred_taken(b_taken), .o_pred_cnt(b_cnt), .o_pred_idx(b_idx),
        .i_upd_valid(b_uv), .i_upd_idx(b_uidx), .i_upd_taken(b_ut), .i_upd_pred(b_up),
        .o_ghr(b_ghr), .o_miss_cnt(b_miss)
    );

    branch_predictor_table #(.GHR_W(4)) dut_g (
        .i_clk(clk), .i_rst(rst_g), .i_pred_pc(g_pc),
        .o_pred_taken(g_taken), .o_pred_cnt(g_cnt), .o_pred_idx(g_idx),
        .i_upd_valid(g_uv), .i_upd_idx(g_uidx), .i_upd_taken(g_ut), .i_upd_pred(g_up),
        .o_ghr(g_ghr), .o_miss_cnt(g_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void mreset(input int k);
        for (int i = 0; i < 64; i++) mc[k][i] = 1;
        mghr[k]  = 0;
        mmiss[k] = 0;
    endfunction

    function automatic int midx(input int k, input logic [31:0] pc);
        return (int'(pc >> 2) % 64) ^ mghr[k];
    endfunction

    function automatic void mupd(input int k, input int idx, input bit t, input bit p);
        if (t) mc[k][idx] = (mc[k][idx] >= 3) ? 3 : mc[k][idx] + 1;
        else   mc[k][idx] = (mc[k][idx] <= 0) ? 0 : mc[k][idx] - 1;
        if (glen[k] > 0) mghr[k] = ((mghr[k] * 2) + int'(t)) % (1 << glen[k]);
        if (t != p && mmiss[k] < 65535) mmiss[k]++;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst_b && b_uv) mupd(0, int'(b_uidx), b_ut, b_up);
        if (rst_g && g_uv) mupd(1, int'(g_uidx), g_ut, g_up);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        rst_g = 1'b0;
        mreset(0);
        mreset(1);
        cyc();
        cyc();
        rst_b = 1'b1;
        rst_g = 1'b1;
    endtask

    task automatic chk_model(input int k);
        int e;
        if (k == 0) begin
            e = midx(0, b_pc);
            chk("rnd_b_idx", b_idx, e);
            chk("rnd_b_cnt", b_cnt, mc[0][e]);
            chk("rnd_b_taken", b_taken, (mc[0][e] >= 2) ? 1 : 0);
            chk("rnd_b_ghr", b_ghr, mghr[0]);
            chk("rnd_b_miss", b_miss, mmiss[0]);
        end else begin
            e = midx(1, g_pc);
            chk("rnd_g_idx", g_idx, e);
            chk("rnd_g_cnt", g_cnt, mc[1][e]);
            chk("rnd_g_taken", g_taken, (mc[1][e] >= 2) ? 1 : 0);
            chk("rnd_g_ghr", g_ghr, mghr[1]);
            chk("rnd_g_miss", g_miss, mmiss[1]);
        end
    endtask

    initial begin
        b_pc = 32'h40; g_pc = 32'h0;
        b_uv = 0; g_uv = 0; b_ut = 0; g_ut = 0; b_up = 0; g_up = 0;
        b_uidx = 0; g_uidx = 0;
        do_reset();

        // Defaults after reset
        #1;
        chk("rst_cnt", b_cnt, 2'b01);
        chk("rst_taken", b_taken, 1'b0);
        chk("rst_idx", b_idx, 6'h10);
        chk("rst_miss", b_miss, 16'd0);
        chk("rst_ghr", g_ghr, 4'h0);

        // Two taken updates, one mispredicted
        b_uv = 1; b_uidx = 6'h10; b_ut = 1; b_up = 0;
        cyc();
        b_up = 1;
        cyc();
        b_uv = 0;
        #1;
        chk("two_taken_cnt", b_cnt, 2'b11);
        chk("two_taken_taken", b_taken, 1'b1);
        chk("two_taken_miss", b_miss, 16'd1);
        b_pc = 32'h44;
        #1;
        chk("isolation_cnt", b_cnt, 2'b01);
        b_pc = 32'h40;

        // Saturation high then walk down
        b_uv = 1; b_ut = 1; b_up = 1;
        repeat (3) cyc();
        b_uv = 0;
        #1;
        chk("sat_hi_cnt", b_cnt, 2'b11);
        b_uv = 1; b_ut = 0; b_up = 0;
        cyc(); chk("nt1_cnt", b_cnt, 2'b10); chk("nt1_taken", b_taken, 1'b1);
        cyc(); chk("nt2_cnt", b_cnt, 2'b01); chk("nt2_taken", b_taken, 1'b0);
        cyc(); chk("nt3_cnt", b_cnt, 2'b00);
        cyc(); chk("nt4_cnt", b_cnt, 2'b00);
        b_uv = 0;
        chk("sat_miss", b_miss, 16'd1);

        // Aliasing through shared index bits
        do_reset();
        b_pc = 32'h40; b_uv = 1; b_uidx = 6'h10; b_ut = 1; b_up = 1;
        cyc(); cyc();
        b_uv = 0; b_pc = 32'h140;
        #1;
        chk("alias_idx", b_idx, 6'h10);
        chk("alias_cnt", b_cnt, 2'b11);

        // Same-cycle read/write: no bypass
        do_reset();
        b_pc = 32'h40; b_uv = 1; b_uidx = 6'h10; b_ut = 1; b_up = 1;
        #1;
        chk("hazard_pre_cnt", b_cnt, 2'b01);
        cyc();
        b_uv = 0;
        #1;
        chk("hazard_post_cnt", b_cnt, 2'b10);

        // gshare history, then asynchronous reset
        do_reset();
        g_uv = 1; g_uidx = 6'h05; g_up = 0;
        g_ut = 1; cyc();
        g_ut = 1; cyc();
        g_ut = 0; cyc();
        g_ut = 1; cyc();
        g_uv = 0; g_pc = 32'h0;
        #1;
        chk("ghr_val", g_ghr, 4'b1101);
        chk("ghr_idx", g_idx, 6'h0D);
        chk("ghr_miss", g_miss, 16'd3);
        g_pc = 32'h20;
        #1;
        chk("ghr_entry_cnt", g_cnt, 2'b11);
        rst_g = 1'b0;
        #1;
        chk("async_ghr", g_ghr, 4'h0);
        chk("async_miss", g_miss, 16'd0);
        for (int i = 0; i < 64; i++) begin
            g_pc = 32'(i * 4);
            #1;
            chk("async_cnt", g_cnt, 2'b01);
        end

        // Randomized traffic on both builds against the reference model
        do_reset();
        repeat (500) begin
            b_pc = $urandom;
            g_pc = $urandom;
            b_uv = 1'($urandom_range(0, 3) != 0);
            g_uv = 1'($urandom_range(0, 3) != 0);
            b_ut = 1'($urandom); g_ut = 1'($urandom);
            b_up = 1'($urandom); g_up = 1'($urandom);
            b_uidx = $urandom_range(0, 1) ? 6'(midx(0, b_pc)) : 6'($urandom);
            g_uidx = $urandom_range(0, 1) ? 6'(midx(1, g_pc)) : 6'($urandom);
            #1;
            chk_model(0);
            chk_model(1);
            cyc();
        end
        b_uv = 0; g_uv = 0;
        #1;
        chk_model(0);
        chk_model(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised branch history table (BHT) of saturating counters. Successor to the single 2-bit predictor.
- Adds per-PC indexing, configurable counter width, and an optional global-history (gshare) mode.
- Adds a saturating mispredict statistics counter.
- Fetch stage reads a prediction combinationally. Execute stage writes back the resolved outcome one or more cycles later.

Parameters:
- PC_W, 32, width of program counter inputs.
- INDEX_W, 6, table index width; table depth = 2**INDEX_W entries.
- CNT_W, 2, counter width per entry; legal range 2..4.
- GHR_W, 0, global history length; 0 = bimodal; 1..INDEX_W = gshare.
- MISS_W, 16, width of mispredict statistics counter.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_pred_pc  in  PC_W  fetch PC to predict.
- o_pred_taken  out  1  prediction for i_pred_pc (counter MSB).
- o_pred_cnt  out  CNT_W  raw counter value at the predicted index.
- o_pred_idx  out  INDEX_W  index used for this prediction; carried down the pipeline.
- i_upd_valid  in  1  resolved-branch update strobe.
- i_upd_idx  in  INDEX_W  index returned from o_pred_idx of that branch.
- i_upd_taken  in  1  actual outcome.
- i_upd_pred  in  1  prediction that was made for that branch.
- o_ghr  out  max(GHR_W,1)  current global history; 0 when GHR_W=0.
- o_miss_cnt  out  MISS_W  number of mispredicted updates.

Behaviour:
- Reset (i_rst low, async):
  - every table entry = weakly-not-taken = 2**(CNT_W-1)-1 (01 for CNT_W=2);
  - GHR = 0;
  - o_miss_cnt = 0.
  - Consequently o_pred_taken=0 and o_pred_cnt=01 immediately after reset.
- Reset asserted mid-operation clears all state within the same cycle, regardless of i_upd_valid.
- Index generation, combinational:
  - base = i_pred_pc[INDEX_W+1:2]; bits [1:0] are ignored.
  - GHR_W=0: o_pred_idx = base.
  - GHR_W>0: o_pred_idx = base XOR zero-extended GHR, so history lands in the low bits.
- Prediction read is combinational, zero latency: o_pred_cnt = table[o_pred_idx]; o_pred_taken = o_pred_cnt[CNT_W-1].
- Update, on rising edge with i_upd_valid=1, entry table[i_upd_idx]:
  - taken: increment, saturate at all-ones;
  - not taken: decrement, saturate at 0.
- GHR update, only on i_upd_valid and only when GHR_W>0: GHR <= {GHR[GHR_W-2:0], i_upd_taken}, LSB newest (GHR_W=1: GHR <= i_upd_taken).
- GHR is non-speculative: it is updated at resolve time only, with no repair logic.
- Mispredict counter: increments on i_upd_valid when i_upd_pred != i_upd_taken; saturates at all-ones with no wrap.
- Read/write same index in the same cycle: the read returns the pre-update value; the new value is visible the cycle after the edge. There is no bypass.
- The prediction read in a cycle with i_upd_valid uses the pre-update GHR.
- i_upd_valid=0: table, GHR and miss counter hold.
- Aliasing is intended behaviour. PCs sharing index bits share one entry; there are no tags.
- Storage is flops; no SRAM macro.
- Illegal parameter values (CNT_W outside 2..4, GHR_W > INDEX_W) must trigger an elaboration-time $error.

Test Plan:
- Defaults, immediately after reset release, i_pred_pc=0x40 -> o_pred_cnt=01, o_pred_taken=0, o_pred_idx=0x10, o_miss_cnt=0.
- Two updates idx 0x10 taken (i_upd_pred=0,1) -> pred at 0x40 cnt=11, taken=1; o_miss_cnt=1; pred at 0x44 still cnt=01 (isolation).
- Saturation at idx 0x10:
  - three further taken updates -> cnt stays 11;
  - then four not-taken -> 10,01,00,00;
  - o_pred_taken falls to 0 after the second not-taken.
- Aliasing: update via pc 0x40 taken twice -> pred at pc 0x140 (idx 0x10) shows cnt=11.
- Same-cycle hazard: i_pred_pc=0x40 with i_upd_valid, idx 0x10, taken, from cnt 01 -> same cycle o_pred_cnt=01; next cycle 10.
- GHR_W=4 build:
  - updates taken,taken,not,taken -> o_ghr=4'b1101;
  - i_pred_pc=0x0 -> o_pred_idx=0x0D;
  - assert i_rst low mid-sequence -> o_ghr=0, all counters 01, o_miss_cnt=0 without waiting for a clock edge.
